// File: rtl/test_if.sv
// test_if: operand/result bundle for the test ALU
interface test_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Fin;
  logic [31:0] Y;
  logic        Cout;
  modport master(output A, B, Fin, input Y, Cout);
  modport slave(input A, B, Fin, output Y, Cout);
endinterface

// File: rtl/test.sv
// test: 32-bit ALU with a single registered result stage
module test (
  input  logic   clk,
  input  logic   reset_n,
  test_if.slave  bus
);
  logic [31:0] y;
  logic        c;
  logic [4:0]  sh;
  logic [32:0] add, sub, inc, sl, sr, sa;
  assign sh  = bus.B[4:0];
  assign add = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub = {1'b0, bus.A} + {1'b0, ~bus.B} + 33'd1;
  assign inc = {1'b0, bus.A} + 33'd1;
  // a guard bit beside A catches the last bit shifted out; zero for a zero shift
  assign sl  = {1'b0, bus.A} << sh;
  assign sr  = {bus.A, 1'b0} >> sh;
  assign sa  = 33'($signed({bus.A, 1'b0}) >>> sh);
  always_comb begin
    y = 32'd0;
    c = 1'b0;
    case (bus.Fin)
      4'h0: y = bus.A & bus.B;
      4'h1: y = bus.A | bus.B;
      4'h2: y = bus.A ^ bus.B;
      4'h3: y = ~(bus.A | bus.B);
      4'h4: {c, y} = add;
      4'h5: {c, y} = sub;
      4'h6: y = bus.A & ~bus.B;
      4'h7: y = bus.A | ~bus.B;
      4'h8: {c, y} = sl;
      4'h9: {y, c} = sr;
      4'ha: {y, c} = sa;
      4'hb: y = {31'd0, $signed(bus.A) < $signed(bus.B)};
      4'hc: y = {31'd0, bus.A < bus.B};
      4'hd: y = bus.A;
      4'he: y = ~bus.A;
      default: {c, y} = inc;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.Y    <= 32'd0;
      bus.Cout <= 1'b0;
    end else begin
      bus.Y    <= y;
      bus.Cout <= c;
    end
endmodule

// File: tb/tb_test.sv
// tb_test: scoreboarded random and directed checks of the test ALU
module tb_test;
  logic clk = 0;
  logic reset_n = 1;
  int cmp = 0;
  int bad = 0;
  logic [32:0] q[$];
  test_if bus();
  test dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] f);
    logic [31:0] y;
    logic c;
    logic [63:0] s;
    int n;
    c = 0;
    n = int'(b[4:0]);
    y = 0;
    case (f)
      4'h0: y = a & b;
      4'h1: y = a | b;
      4'h2: y = a ^ b;
      4'h3: y = ~(a | b);
      4'h4: begin s = {32'd0, a} + {32'd0, b}; y = s[31:0]; c = s[32]; end
      4'h5: begin y = a - b; c = a >= b; end
      4'h6: y = a & ~b;
      4'h7: y = a | ~b;
      4'h8: begin y = a; for (int i = 0; i < n; i++) begin c = y[31]; y = y << 1; end end
      4'h9: begin y = a; for (int i = 0; i < n; i++) begin c = y[0]; y = y >> 1; end end
      4'ha: begin y = a; for (int i = 0; i < n; i++) begin c = y[0]; y = {y[31], y[31:1]}; end end
      4'hb: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hc: y = (a < b) ? 32'd1 : 32'd0;
      4'hd: y = a;
      4'he: y = ~a;
      default: begin y = a + 1; c = (a == 32'hffffffff); end
    endcase
    return {c, y};
  endfunction

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got Cout=%0b Y=%08h, want Cout=%0b Y=%08h", name, act[32], act[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, logic [3:0] f);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Fin = f;
    q.push_back(model(a, b, f));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    #2;
    cmp++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset_n && q.size() > 0) check("scoreboard", {bus.Cout, bus.Y}, q.pop_front());
  end

  initial begin
    bus.A = 32'hffffffff;
    bus.B = 32'h1;
    bus.Fin = 4'hd;
    #7;
    check("pre_reset_pass", {bus.Cout, bus.Y}, {1'b0, 32'hffffffff});
    bus.Fin = 4'h4;
    reset_n = 0;
    #1;
    check("async_reset", {bus.Cout, bus.Y}, 33'd0);
    @(negedge clk);
    reset_n = 1;
    q.push_back(model(32'hffffffff, 32'h1, 4'h4));
    drain();
    for (int f = 0; f < 16; f++) issue(32'h0000ffff, 32'hffff0000, 4'(f));
    issue(32'h000fffff, 32'hffff0000, 4'h0);
    issue(32'h000fffff, 32'hffff0000, 4'h4);
    issue(32'h000fffff, 32'hffff0000, 4'h5);
    issue(32'h80000001, 32'h1, 4'h8);
    issue(32'h80000001, 32'h1, 4'h9);
    issue(32'h80000001, 32'h1, 4'ha);
    issue(32'h80000001, 32'h1f, 4'h8);
    issue(32'h80000001, 32'h1f, 4'ha);
    issue(32'hffffffff, 32'h0, 4'hb);
    issue(32'hffffffff, 32'h0, 4'hc);
    issue(32'hffffffff, 32'h0, 4'hf);
    issue(32'h5, 32'h5, 4'h5);
    drain();
    issue(32'h12345678, 32'h0, 4'hd);
    @(posedge clk);
    #3;
    bus.Fin = 4'he;
    #1;
    check("latency_hold", {bus.Cout, bus.Y}, {1'b0, 32'h12345678});
    q.push_back(model(32'h12345678, 32'h0, 4'he));
    drain();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hffffffff;
        1: b = a;
        2: a = 32'h80000000;
        3: b = {27'($urandom), 5'd0};
        default: ;
      endcase
      issue(a, b, 4'($urandom_range(0, 15)));
    end
    drain();
    @(negedge clk);
    bus.A = 32'hdeadbeef;
    bus.Fin = 4'hd;
    #2;
    reset_n = 0;
    #1;
    check("reset_midop", {bus.Cout, bus.Y}, 33'd0);
    @(negedge clk);
    bus.A = 32'h0badf00d;
    reset_n = 1;
    q.push_back(model(32'h0badf00d, bus.B, 4'hd));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/test.md
TEST -- requirements
Module: test

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all registered state.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: A  input  32  operand A, unsigned or two's-complement per operation.
REQ-005 Port: B  input  32  operand B; B[4:0] is the shift amount for shift operations.
REQ-006 Port: Fin  input  4  operation select.
REQ-007 Port: Y  output  32  registered result.
REQ-008 Port: Cout  output  1  registered carry/shift-out flag.
REQ-009 SHALL have no parameters; data width is fixed at 32.

Function
REQ-010 SHALL compute the result combinationally from A, B and Fin, and register it into Y/Cout on every rising clk edge; latency is 1 cycle, throughput is 1 operation per cycle, and there is no handshake.
REQ-011 SHALL implement this Fin map, with Cout=0 unless stated: 0000 A&B; 0001 A|B; 0010 A^B; 0011 ~(A|B).
REQ-012 SHALL implement: 0100 ADD A+B, Cout=bit 32 of the 33-bit sum; 0101 SUB A+~B+1, Cout=bit 32 (1 = no borrow).
REQ-013 SHALL implement: 0110 A&~B; 0111 A|~B.
REQ-014 SHALL implement: 1000 SLL A<<B[4:0]; 1001 SRL logical A>>B[4:0]; 1010 SRA arithmetic A>>>B[4:0]; Cout=last bit shifted out, 0 when B[4:0]=0.
REQ-015 SHALL implement: 1011 SLT Y={31'b0, signed(A)<signed(B)}; 1100 SLTU Y={31'b0, A<B unsigned}.
REQ-016 SHALL implement: 1101 PASS Y=A; 1110 NOT Y=~A; 1111 INC Y=A+1, Cout=carry out (1 only when A=FFFFFFFF).
REQ-017 Arithmetic SHALL wrap modulo 2^32; no overflow flag; B[31:5] SHALL be ignored for shifts.
REQ-018 A change in Fin, A or B between edges SHALL affect outputs only at the next rising edge; outputs SHALL hold between edges.
REQ-019 SHALL contain no unknown-producing paths: every Fin value is defined, with no default-to-X.

Reset
REQ-020 While reset_n=0, Y SHALL be 32'h00000000 and Cout SHALL be 0, asserted immediately and independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard the pending result; the first clk edge with reset_n=1 SHALL register the current inputs.
REQ-022 No other state exists; no reset-release synchronisation is required inside the block.

Verification
REQ-023 Reset: reset_n=0 with A=FFFFFFFF, B=1, Fin=0100 -> Y=00000000, Cout=0 with no clock edge; after release and one edge -> Y=00000000, Cout=1.
REQ-024 A=0000FFFF, B=FFFF0000, Fin swept 0000..1111 one per cycle -> one cycle later in order:
 Y = 00000000, FFFFFFFF, FFFFFFFF, 00000000,
 FFFFFFFF (Cout 0), 0001FFFF (Cout 0),
 0000FFFF, 0000FFFF, 0000FFFF, 0000FFFF, 0000FFFF,
 00000000, 00000001, 0000FFFF, FFFF0000, 00010000;
 Cout=0 for all of them.
REQ-025 A=000FFFFF, B=FFFF0000: Fin=0000 -> Y=000F0000; Fin=0100 -> Y=000EFFFF, Cout=1; Fin=0101 -> Y=0010FFFF, Cout=0.
REQ-026 Shifts: A=80000001, B=00000001: SLL -> Y=00000002, Cout=1; SRL -> Y=40000000, Cout=1; SRA -> Y=C0000000, Cout=1.
REQ-027 Signed compare and INC boundary: A=FFFFFFFF, B=00000000: SLT -> Y=1; SLTU -> Y=0; INC -> Y=00000000, Cout=1.
REQ-028 Latency: change Fin mid-cycle -> Y is unchanged until the next rising edge, then matches the new Fin.
